raw_unpacker: RTL

RAW_UNPACKER -- requirements
Module: raw_unpacker

---
 rtl/raw_unpacker.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/raw_unpacker.sv
// raw_unpacker: unpacks a multi-lane byte stream into MSB-aligned RAW8 pixels, plus RAW10
// (4 pixels per 5-byte group) when RAW_UNPACKER_RAW10_EN is defined; format is ignored otherwise.
module raw_unpacker #(
    parameter int unsigned NUM_LANES   = 2,
    parameter int unsigned PIXEL_WIDTH = 10,
    parameter int unsigned BUF_BYTES   = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   format,
    input  logic                   line_start,
    input  logic                   in_valid,
    input  logic [NUM_LANES*8-1:0] in_data,
    output logic                   in_ready,
    output logic [PIXEL_WIDTH-1:0] pixel,
    output logic                   pixel_valid,
    input  logic                   pixel_ready,
    output logic                   pixel_sol,
    output logic                   overflow
);
    localparam int unsigned CNT_W     = $clog2(BUF_BYTES + 1);
    localparam int unsigned IDX_W     = $clog2(BUF_BYTES);
    localparam int unsigned ALIGN_SH  = 16 - PIXEL_WIDTH;
    localparam int unsigned READY_MAX = BUF_BYTES - NUM_LANES;

    logic [7:0]             fifo_q [BUF_BYTES];
    logic [7:0]             fifo_d [BUF_BYTES];
    logic [CNT_W-1:0]       count_q, count_d;
    logic [PIXEL_WIDTH-1:0] pixel_q, pixel_d;
    logic                   pixel_valid_q, pixel_valid_d;
    logic                   pixel_sol_q, pixel_sol_d;
    logic                   overflow_q, overflow_d;
    logic                   sol_arm_q, sol_arm_d;

    logic                   push;
    logic                   load;
    logic                   avail;
    logic [PIXEL_WIDTH-1:0] cand;
    int unsigned            pop_n;
    int unsigned            pop_eff;
    int unsigned            base;

`ifdef RAW_UNPACKER_RAW10_EN
    logic                   fmt_q, fmt_d;
    logic [1:0]             phase_q, phase_d;
    logic [9:0]             raw10;
`else
    logic                   unused_format;
    assign unused_format = format;
`endif

    assign in_ready    = (count_q <= CNT_W'(READY_MAX)) && !reset;
    assign push        = in_valid && in_ready;
    assign pixel       = pixel_q;
    assign pixel_valid = pixel_valid_q;
    assign pixel_sol   = pixel_sol_q;
    assign overflow    = overflow_q;

    // Candidate pixel at the buffer head and how many bytes loading it consumes
    always_comb begin
        avail = (count_q != '0);
        pop_n = 1;
        cand  = PIXEL_WIDTH'({fifo_q[0], 8'h00} >> ALIGN_SH);
`ifdef RAW_UNPACKER_RAW10_EN
        raw10 = {fifo_q[IDX_W'(phase_q)], fifo_q[4][{phase_q, 1'b0} +: 2]};
        if (fmt_q) begin
            avail = (count_q >= CNT_W'(5));
            pop_n = (phase_q == 2'd3) ? 5 : 0;
            cand  = PIXEL_WIDTH'({raw10, 6'h00} >> ALIGN_SH);
        end
`endif
    end

    // Buffer shift/append, output stage and sticky flags
    always_comb begin
        load    = (!pixel_valid_q || pixel_ready) && avail && !line_start;
        pop_eff = load ? pop_n : 0;
        base    = line_start ? 0 : (32'(count_q) - pop_eff);

        for (int unsigned i = 0; i < BUF_BYTES; i++) begin
            if (i + pop_eff < BUF_BYTES) begin
                fifo_d[i] = fifo_q[IDX_W'(i + pop_eff)];
            end else begin
                fifo_d[i] = 8'h00;
            end
        end
        if (push) begin
            for (int unsigned l = 0; l < NUM_LANES; l++) begin
                if (base + l < BUF_BYTES) begin
                    fifo_d[IDX_W'(base + l)] = in_data[8*l +: 8];
                end
            end
        end
        count_d = CNT_W'(base + (push ? NUM_LANES : 0));

        pixel_d       = pixel_q;
        pixel_valid_d = pixel_valid_q;
        pixel_sol_d   = pixel_sol_q;
        if (load) begin
            pixel_d       = cand;
            pixel_valid_d = 1'b1;
            pixel_sol_d   = sol_arm_q;
        end else if (pixel_ready) begin
            pixel_valid_d = 1'b0;
            pixel_sol_d   = 1'b0;
        end

        sol_arm_d = sol_arm_q;
        if (load) begin
            sol_arm_d = 1'b0;
        end
        if (line_start) begin
            sol_arm_d = 1'b1;
        end

        overflow_d = overflow_q || (in_valid && !in_ready);
    end

`ifdef RAW_UNPACKER_RAW10_EN
    // Pixel index within the current 5-byte group
    always_comb begin
        fmt_d   = fmt_q;
        phase_d = phase_q;
        if (load && fmt_q) begin
            phase_d = phase_q + 2'd1;
        end
        if (line_start) begin
            fmt_d   = format;
            phase_d = 2'd0;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q       <= '0;
            pixel_q       <= '0;
            pixel_valid_q <= 1'b0;
            pixel_sol_q   <= 1'b0;
            overflow_q    <= 1'b0;
            sol_arm_q     <= 1'b1;
`ifdef RAW_UNPACKER_RAW10_EN
            fmt_q         <= 1'b0;
            phase_q       <= 2'd0;
`endif
        end else begin
            count_q       <= count_d;
            pixel_q       <= pixel_d;
            pixel_valid_q <= pixel_valid_d;
            pixel_sol_q   <= pixel_sol_d;
            overflow_q    <= overflow_d;
            sol_arm_q     <= sol_arm_d;
`ifdef RAW_UNPACKER_RAW10_EN
            fmt_q         <= fmt_d;
            phase_q       <= phase_d;
`endif
        end
    end

    // Byte storage needs no reset: count_q alone defines which entries are live
    always_ff @(posedge clk) begin
        fifo_q <= fifo_d;
    end

endmodule
